// File: rtl/fifo_pkg.sv
// Shared types and constants for the synchronous FIFO read path.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int RD_BUF_DEPTH    = 2;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

  // Words held in the output buffer plus the one possibly on its way from the FIFO.
  function automatic logic [1:0] rd_occ(input logic [1:0] cnt, input logic inflight);
    return cnt + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry circular output buffer for the FIFO read controller.
// A write strobe captures the word returned by the FIFO; a read strobe retires
// the head word. Flush empties the buffer and drops a same-edge write.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = $clog2(RD_BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  mem_we;

  assign mem_we = wr_en && !flush;

  // Next indices and fill count; flush wins over any capture or retire.
  always_comb begin
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_idx_d = wr_idx_q + 1'b1;
      if (rd_en) rd_idx_d = rd_idx_q + 1'b1;
      cnt_d = cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Storage update; contents survive reset and flush.
  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[wr_idx_q] = wr_data;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage register, deliberately without reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_idx_q];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the synchronous FIFO: issues pops, absorbs the
// FIFO's one-cycle read latency in a two-entry buffer and streams words out
// on valid/ready at up to one word per cycle.
// Optional statistics counters (words_out, stall_cyc) are built when
// FIFO_RD_STATS_EN is defined.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  stall_cyc
`endif
);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("fifo_rd_ctrl: CNT_WIDTH must be at least 1");
  end

  logic       inflight_q, inflight_d;
  logic [1:0] cnt;
  logic [1:0] occ;
  logic       xfer;

  assign occ     = rd_occ(cnt, inflight_q);
  assign m_valid = (cnt != 2'd0);
  assign xfer    = m_valid && m_ready;

  // Pop request: room for another word, or a slot freeing this very edge.
  // The m_ready term keeps the pipe at one word per cycle; rst_n holds pop
  // low while reset is asserted.
  always_comb begin
    fifo_pop = 1'b0;
    if (rst_n && !flush && !fifo_empty) begin
      fifo_pop = (occ < 2'd2) || (occ == 2'd2 && cnt != 2'd0 && m_ready);
    end
    inflight_d = fifo_pop;
  end

  // In-flight flag: a pop accepted this edge returns data next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (inflight_q),
    .wr_data (fifo_data),
    .rd_en   (xfer),
    .cnt     (cnt),
    .rd_data (m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  // Saturating counters of delivered words and backpressure cycles; flush
  // leaves them alone.
  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (xfer && words_q != {CNT_WIDTH{1'b1}})
      words_d = words_q + 1'b1;
    if (m_valid && !m_ready && stall_q != {CNT_WIDTH{1'b1}})
      stall_d = stall_q + 1'b1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign words_out = words_q;
  assign stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a behavioural FIFO model and an
// expected-word scoreboard. Stats checks are built with FIFO_RD_STATS_EN.
module tb_fifo_rd_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] words_out;
  logic [CW-1:0] stall_cyc;
`endif

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out  (words_out),
    .stall_cyc  (stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered read data, one cycle after an accepted pop.
  logic [DW-1:0] fmem [16];
  int head = 0;
  int tail = 0;
  int pop_cnt = 0;
  assign fifo_empty = (head == tail);

  always @(posedge clk) begin
    if (fifo_pop && !fifo_empty) begin
      fifo_data <= fmem[head % 16];
      head      <= head + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic fifo_push(input logic [DW-1:0] v, input bit expect_out);
    fmem[tail % 16] = v;
    tail = tail + 1;
    if (expect_out) exp_q.push_back(v);
  endtask

  // Monitor sampled 3 time units after negedge (inputs settle at +1).
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      chk("pop_while_empty", {31'd0, fifo_pop && fifo_empty}, 32'd0);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("sb_avail", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("sb_data", m_data, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int pops0;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] words0, stall0;
`endif

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Reset and idle.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_pop", {31'd0, fifo_pop}, 32'd0);
      chk("idle_valid", {31'd0, m_valid}, 32'd0);
      step(1);
    end
`ifdef FIFO_RD_STATS_EN
    chk("idle_words", 32'(words_out), 32'd0);
    chk("idle_stall", 32'(stall_cyc), 32'd0);
`endif

    // Burst with m_ready held high.
    pops0 = pop_cnt;
`ifdef FIFO_RD_STATS_EN
    words0 = words_out;
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_push(32'hA0 + i, 1'b1);
    #1;
    chk("burst_pop0", {31'd0, fifo_pop}, 32'd1);
    chk("burst_v0", {31'd0, m_valid}, 32'd0);
    step(1);
    #1;
    chk("burst_v1", {31'd0, m_valid}, 32'd0);
    step(1);
    #1;
    chk("burst_first", m_data, 32'hA0);
    for (int i = 0; i < 8; i++) begin
      chk("burst_valid", {31'd0, m_valid}, 32'd1);
      step(1);
      #1;
    end
    chk("burst_end", {31'd0, m_valid}, 32'd0);
    chk("burst_pops", 32'(pop_cnt - pops0), 32'd8);
    chk("burst_sb", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("burst_words", 32'(words_out - words0), 32'd8);
`endif

    // Backpressure on edges 3..7 after the first pop.
    step(1);
    pops0 = pop_cnt;
`ifdef FIFO_RD_STATS_EN
    words0 = words_out;
    stall0 = stall_cyc;
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_push(32'hA0 + i, 1'b1);
    step(2);
    m_ready = 1'b0;
    #1;
    chk("bp_pop_held", {31'd0, fifo_pop}, 32'd0);
    step(2);
    #1;
    chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold_data", m_data, 32'hA0);
    chk("bp_pop_held2", {31'd0, fifo_pop}, 32'd0);
    step(3);
    m_ready = 1'b1;
    step(12);
    chk("bp_pops", 32'(pop_cnt - pops0), 32'd8);
    chk("bp_sb", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("bp_words", 32'(words_out - words0), 32'd8);
    chk("bp_stall", 32'(stall_cyc - stall0), 32'd5);
`endif

    // Single word: FIFO goes empty while the word is in flight.
    pops0 = pop_cnt;
    fifo_push(32'h55, 1'b1);
    step(6);
    chk("one_pops", 32'(pop_cnt - pops0), 32'd1);
    chk("one_sb", 32'(exp_q.size()), 32'd0);
    chk("one_idle", {31'd0, m_valid}, 32'd0);

    // Flush with 0x11 buffered and 0x22 in flight.
    m_ready = 1'b0;
    fifo_push(32'h11, 1'b0);
    fifo_push(32'h22, 1'b0);
    fifo_push(32'h33, 1'b1);
    fifo_push(32'h44, 1'b1);
    step(2);
    #1;
    chk("fl_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("fl_pre_data", m_data, 32'h11);
    flush = 1'b1;
    #1;
    chk("fl_pop_forced", {31'd0, fifo_pop}, 32'd0);
    step(1);
    #1;
    chk("fl_valid_drop", {31'd0, m_valid}, 32'd0);
    flush   = 1'b0;
    m_ready = 1'b1;
    step(8);
    chk("fl_sb", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 8; i++) fifo_push(32'hC0 + i, 1'b1);
    step(4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("rst_words", 32'(words_out), 32'd0);
    chk("rst_stall", 32'(stall_cyc), 32'd0);
`endif
    exp_q.delete();
    tail = head;
    step(2);
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", {31'd0, m_valid}, 32'd0);

    // Recovery after reset.
    pops0 = pop_cnt;
    fifo_push(32'hD0, 1'b1);
    fifo_push(32'hD1, 1'b1);
    step(6);
    chk("rec_pops", 32'(pop_cnt - pops0), 32'd2);
    chk("rec_sb", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
